freq_detect_scheduler: RTL

//  Time-shares one freq_detect instance across NCH test clocks. Selects a test clock

---
 rtl/freq_detect_scheduler.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/freq_detect_scheduler.sv
// Time-shares one freq_detect instance across NCH test clocks. A round-robin
// sweeper steers the test-clock mux, lets it settle, starts a measurement,
// and waits for Finish with a timeout. It keeps sticky per-channel
// Warning/Stuck flags and the last result. A timeout parks the scheduler
// until Clear_i is pulsed.
module freq_detect_scheduler #(
    parameter int unsigned NCH     = 4,
    parameter int unsigned CW      = 2,
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned SETTLE  = 8,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic             Clk_ref_i_muxed,
    input  logic             rstn_muxed,
    input  logic             Enable_i,
    input  logic [NCH-1:0]   ChMask_i,
    input  logic [15:0]      Period_i,
    input  logic             Clear_i,
    input  logic             Det_Finish_i,
    input  logic             Det_Warning_i,
    input  logic             Det_Stuck_i,
    input  logic [WIDTH-1:0] Det_Result_i,
    output logic             Det_Start_o,
    output logic [CW-1:0]    ClkSel_o,
    output logic [NCH-1:0]   ChWarning_o,
    output logic [NCH-1:0]   ChStuck_o,
    output logic [WIDTH-1:0] Result_o,
    output logic [CW-1:0]    ResultCh_o,
    output logic             ResultValid_o,
    output logic             SweepDone_o,
    output logic             Fault_o,
    output logic [CW-1:0]    FaultCh_o
);

    // One shared counter serves SETTLE, TIMEOUT and the 16-bit gap period.
    localparam int unsigned CNT_W = 17;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_START,
        S_WAIT,
        S_NEXT,
        S_GAP,
        S_HALT
    } state_t;

    state_t           state;
    logic [NCH-1:0]   mask_q;
    logic [CW-1:0]    ch;
    logic [CNT_W-1:0] cnt;

    logic             lo_found;
    logic [CW-1:0]    lo_ch;
    logic             nx_found;
    logic [CW-1:0]    nx_ch;
    logic             fin_set;
    logic             to_set;
    logic [NCH-1:0]   ch_bit;

    // Lowest enabled channel in the live mask, used to open a sweep.
    always_comb begin
        lo_found = 1'b0;
        lo_ch    = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (ChMask_i[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_ch    = CW'(i);
            end
        end
    end

    // Next enabled channel above the current one in the latched mask.
    // The search never wraps, so a sweep always ends after its highest channel.
    always_comb begin
        nx_found = 1'b0;
        nx_ch    = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (mask_q[i] && (CW'(i) > ch) && !nx_found) begin
                nx_found = 1'b1;
                nx_ch    = CW'(i);
            end
        end
    end

    assign fin_set = (state == S_WAIT) && Det_Finish_i;
    assign to_set  = (state == S_WAIT) && !Det_Finish_i && (cnt == CNT_W'(TIMEOUT - 1));
    assign ch_bit  = NCH'(1) << ch;

    // Sweep sequencer: channel select, settle, start pulse, wait, advance, gap.
    always_ff @(posedge Clk_ref_i_muxed or negedge rstn_muxed) begin
        if (!rstn_muxed) begin
            state         <= S_IDLE;
            mask_q        <= '0;
            ch            <= '0;
            cnt           <= '0;
            Det_Start_o   <= 1'b0;
            ClkSel_o      <= '0;
            Result_o      <= '0;
            ResultCh_o    <= '0;
            ResultValid_o <= 1'b0;
            SweepDone_o   <= 1'b0;
        end else begin
            Det_Start_o   <= 1'b0;
            ResultValid_o <= 1'b0;
            SweepDone_o   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Enable_i && lo_found) begin
                        mask_q   <= ChMask_i;
                        ch       <= lo_ch;
                        ClkSel_o <= lo_ch;
                        cnt      <= '0;
                        state    <= S_SEL;
                    end
                end
                S_SEL: begin
                    if (cnt == CNT_W'(SETTLE - 1)) begin
                        cnt         <= '0;
                        Det_Start_o <= 1'b1;
                        state       <= S_START;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_START: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (fin_set) begin
                        Result_o      <= Det_Result_i;
                        ResultCh_o    <= ch;
                        ResultValid_o <= 1'b1;
                        state         <= S_NEXT;
                    end else if (to_set) begin
                        state <= S_HALT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_NEXT: begin
                    if (!Enable_i) begin
                        state <= S_IDLE;
                    end else if (nx_found) begin
                        ch       <= nx_ch;
                        ClkSel_o <= nx_ch;
                        cnt      <= '0;
                        state    <= S_SEL;
                    end else begin
                        SweepDone_o <= 1'b1;
                        if (Period_i == 16'd0) begin
                            state <= S_IDLE;
                        end else begin
                            cnt   <= CNT_W'(1);
                            state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (cnt >= {1'b0, Period_i}) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_HALT: begin
                    if (Clear_i) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Sticky flags and fault record; a flag raised in the clear cycle survives.
    always_ff @(posedge Clk_ref_i_muxed or negedge rstn_muxed) begin
        if (!rstn_muxed) begin
            ChWarning_o <= '0;
            ChStuck_o   <= '0;
            Fault_o     <= 1'b0;
            FaultCh_o   <= '0;
        end else begin
            ChWarning_o <= (Clear_i ? {NCH{1'b0}} : ChWarning_o)
                         | ((fin_set && Det_Warning_i) ? ch_bit : {NCH{1'b0}});
            ChStuck_o   <= (Clear_i ? {NCH{1'b0}} : ChStuck_o)
                         | ((fin_set && Det_Stuck_i) ? ch_bit : {NCH{1'b0}});
            if (to_set) begin
                Fault_o   <= 1'b1;
                FaultCh_o <= ch;
            end else if (Clear_i) begin
                Fault_o   <= 1'b0;
                FaultCh_o <= '0;
            end
        end
    end

endmodule
